enc_bin2gray_arb: RTL
=====================

# enc_bin2gray_arb

Round-robin arbiter and sequencer that shares one binary-to-Gray conversion stage among several requesters. Each requester offers a binary word over a valid/ready handshake. The block grants one requester per cycle, converts the word, and presents the Gray result on a single registered output port tagged with the requester ID. It sits between pointer/counter producers (FIFO write/read pointers, position counters) and any consumer that needs Gray-coded values, so the conversion logic is not replicated per producer.

## Interface
- WIDTH, 10, data width of binary input and Gray output (≥2)
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), width of requester ID
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester word valid
- req_ready  out  NREQ  per-requester accept strobe, one-hot or zero
- req_bin  in  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  converted result valid
- out_ready  in  1  consumer accepts result
- out_gray  out  WIDTH  Gray-coded result
- out_id  out  IDW  index of requester that produced out_gray
- conv_count  out  16  number of completed input transfers, wraps

## Operation
- Gray rule: gray[WIDTH-1] = bin[WIDTH-1]; gray[k] = bin[k+1] ^ bin[k] for k < WIDTH-1. No inversion of any bit.
- State: output register (out_valid, out_gray, out_id), round-robin pointer ptr (IDW bits), conv_count.
- can_accept = !out_valid || out_ready.
- Arbitration: search req_valid starting at ptr, ascending, wrapping at NREQ-1→0. First valid index g is the winner.
- req_ready[g] = can_accept && req_valid[g]. All other req_ready are 0. When no request is valid or can_accept=0, req_ready is all 0.
- Transfer on requester g (req_valid[g] && req_ready[g]):
  - load out_gray ← gray(req_bin[g]) and out_id ← g
  - set out_valid ← 1
  - ptr ← (g+1) mod NREQ
  - conv_count ← conv_count+1, wrapping 0xFFFF→0x0000
- Drain with no new transfer (out_valid && out_ready, no grant): out_valid ← 0. out_gray and out_id hold their last value.
- Simultaneous drain and transfer: the new result replaces the old in the same edge. out_valid stays 1.
- Stall (out_valid && !out_ready): out_gray and out_id are held stable, and ptr does not move.
- ptr changes only on a transfer. Idle cycles do not rotate priority.
- A requester may drop req_valid at any time. No grant is reserved for it.
- Effect of NREQ not a power of two: ID values ≥ NREQ never occur.

## Timing
- Reset (async assert): out_valid=0, out_gray=0, out_id=0, ptr=0, conv_count=0. req_ready is 0 while rst=1.
- Latency: 1 cycle from input transfer edge to out_valid=1 carrying that word.
- Throughput: 1 conversion per cycle when out_ready is held 1.
- req_ready is combinational from req_valid, out_valid, out_ready and ptr. No combinational path from req_bin to any output.
- Reset mid-operation discards any pending result with no output transfer. After reset release, priority restarts at requester 0.

## Structure
- Shared package holds:
  - the Gray conversion function `bin2gray(bin)`
  - a next-index helper `rr_next(idx, n)`
  - counter width constant `CONV_CNT_W = 16`
- One sub-module is natural: `rr_arbiter` (NREQ-wide round-robin priority select). It takes req and ptr and produces a one-hot grant and the encoded index.
- Conversion stays inline via the package function.

## Test plan
- Reset then single request: req_valid=0001, req_bin[0]=0x2D5, out_ready=1.
  - Next cycle out_valid=1, out_gray=0x3BF, out_id=0, conv_count=1.
- All four requesting continuously, out_ready=1:
  - bins 0x001, 0x3FF, 0x200, 0x155 give grant order 0,1,2,3,0,…
  - outputs 0x001, 0x200, 0x300, 0x1FF; ptr wraps 3→0.
- Backpressure: result pending with out_ready=0 for 5 cycles.
  - req_ready all 0, out_gray/out_id stable, ptr unchanged.
  - On out_ready=1, pending result drains and the next grant loads in the same edge.
- Fairness after idle: grant requester 2 (ptr→3), idle 3 cycles, then req_valid=0101.
  - Requester 0 is granted first, not 2.
- Async reset asserted mid-stall with out_valid=1:
  - outputs go to 0 immediately, without waiting for a clock edge.
  - After release, req_valid=1111 grants requester 0.
- conv_count wrap: preload via 65535 transfers, one more transfer gives conv_count=0x0000.

Source files
------------

// File: rtl/enc_bin2gray_arb_pkg.sv
// Shared helpers for the Gray-conversion arbiter: conversion function,
// round-robin index step and counter width.
package enc_bin2gray_arb_pkg;

  localparam int CONV_CNT_W = 16;
  localparam int GRAY_MAXW  = 32;  // widest word bin2gray handles
  localparam int IDX_W      = 5;   // covers indices up to 31

  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] n);
    return (idx == n - 1'b1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/enc_bin2gray_arb_rr_arbiter.sv
// Round-robin priority select: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);

  always_comb begin
    logic [IDW-1:0] w_idx;
    w_idx = '0;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        gidx         = w_idx;
      end
    end
  end

endmodule

// File: rtl/enc_bin2gray_arb.sv
// Shares one binary-to-Gray stage among NREQ requesters; round-robin grant,
// single registered output tagged with the requester index.
module enc_bin2gray_arb
  import enc_bin2gray_arb_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_gray,
  output logic [IDW-1:0]         out_id,
  output logic [CONV_CNT_W-1:0]  conv_count
);

  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_out_gray;
  logic [IDW-1:0]        r_out_id;
  logic [IDW-1:0]        r_ptr;
  logic [CONV_CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]      w_grant;
  logic [IDW-1:0]       w_gidx;
  logic                 w_any;
  logic                 w_can_accept;
  logic                 w_xfer;
  logic [WIDTH-1:0]     w_sel_bin;
  logic [GRAY_MAXW-1:0] w_gray;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .gidx  (w_gidx),
    .any   (w_any)
  );

  assign w_can_accept = !r_out_valid || out_ready;
  // rst gates ready directly so no handshake completes while reset is held
  assign w_xfer       = w_any && w_can_accept && !rst;
  assign req_ready    = w_xfer ? w_grant : '0;

  assign w_sel_bin = req_bin[w_gidx*WIDTH +: WIDTH];
  assign w_gray    = bin2gray(GRAY_MAXW'(w_sel_bin));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_gray  <= '0;
      r_out_id    <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_gray  <= w_gray[WIDTH-1:0];
      r_out_id    <= w_gidx;
      r_ptr       <= IDW'(rr_next(IDX_W'(w_gidx), IDX_W'(NREQ)));
      r_cnt       <= r_cnt + 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_gray   = r_out_gray;
  assign out_id     = r_out_id;
  assign conv_count = r_cnt;

endmodule
